// File: rtl/cpu_pkg.sv
// Shared widths, ALU-op encodings and the control bundle used by the ID/EX pipeline register.
package cpu_pkg;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_SUB    = 2'd1,
    ALU_R_TYPE = 2'd2
  } alu_op_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

  // A bubble decodes as a harmless R-type with every side effect disabled.
  localparam ctrl_t BUBBLE_CTRL = ctrl_t'{ALU_R_TYPE, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b0, 1'b0, 1'b0, 1'b0};
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             valid_ex,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             stall_req
);
  always_comb begin
    stall_req = valid_ex & mem_read_ex & (rt_ex != '0) &
                ((rt_ex == rs_id) | (rt_ex == rt_id));
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on load-use hazards and a saturating bubble counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] STALL_CNT_RESET = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [1:0]  alu_op,
  input  logic        reg_dst,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_2_reg,
  input  logic        mem_write,
  input  logic        alu_src,
  input  logic        reg_write,
  input  logic        jump,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic [4:0]  rd_id,
  input  logic [31:0] data1_id,
  input  logic [31:0] data2_id,
  input  logic [31:0] imm_id,
  input  logic [31:0] pc_id,
  input  logic [5:0]  funct_id,
  output logic [1:0]  alu_op_ex,
  output logic        reg_dst_ex,
  output logic        branch_ex,
  output logic        mem_read_ex,
  output logic        mem_2_reg_ex,
  output logic        mem_write_ex,
  output logic        alu_src_ex,
  output logic        reg_write_ex,
  output logic        jump_ex,
  output logic [4:0]  rs_ex,
  output logic [4:0]  rt_ex,
  output logic [4:0]  rd_ex,
  output logic [31:0] data1_ex,
  output logic [31:0] data2_ex,
  output logic [31:0] imm_ex,
  output logic [31:0] pc_ex,
  output logic [5:0]  funct_ex,
  output logic        valid_ex,
  output logic [4:0]  wr_addr_ex,
  output logic        stall_req,
  output logic [15:0] stall_cnt
);
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_id;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] data1_q, data2_q, imm_q, pc_q;
  logic [5:0]        funct_q;
  logic              valid_q;
  logic [15:0]       cnt_q;

  assign ctrl_id = ctrl_t'{alu_op, reg_dst, branch, mem_read, mem_2_reg,
                           mem_write, alu_src, reg_write, jump};

  hazard_detect u_hazard (
    .valid_ex    (valid_q),
    .mem_read_ex (ctrl_q.mem_read),
    .rt_ex       (rt_q),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .stall_req   (stall_req)
  );

  // Bubbles only rewrite control and valid; data/address fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= BUBBLE_CTRL;
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      funct_q <= '0;
      cnt_q   <= STALL_CNT_RESET;
    end else if (flush) begin
      ctrl_q  <= BUBBLE_CTRL;
      valid_q <= 1'b0;
    end else if (en && stall_req) begin
      ctrl_q  <= BUBBLE_CTRL;
      valid_q <= 1'b0;
      if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
    end else if (en) begin
      ctrl_q  <= ctrl_id;
      valid_q <= 1'b1;
      rs_q    <= rs_id;
      rt_q    <= rt_id;
      rd_q    <= rd_id;
      data1_q <= data1_id;
      data2_q <= data2_id;
      imm_q   <= imm_id;
      pc_q    <= pc_id;
      funct_q <= funct_id;
    end
  end

  assign alu_op_ex    = ctrl_q.alu_op;
  assign reg_dst_ex   = ctrl_q.reg_dst;
  assign branch_ex    = ctrl_q.branch;
  assign mem_read_ex  = ctrl_q.mem_read;
  assign mem_2_reg_ex = ctrl_q.mem_2_reg;
  assign mem_write_ex = ctrl_q.mem_write;
  assign alu_src_ex   = ctrl_q.alu_src;
  assign reg_write_ex = ctrl_q.reg_write;
  assign jump_ex      = ctrl_q.jump;
  assign rs_ex        = rs_q;
  assign rt_ex        = rt_q;
  assign rd_ex        = rd_q;
  assign data1_ex     = data1_q;
  assign data2_ex     = data2_q;
  assign imm_ex       = imm_q;
  assign pc_ex        = pc_q;
  assign funct_ex     = funct_q;
  assign valid_ex     = valid_q;
  assign stall_cnt    = cnt_q;
  assign wr_addr_ex   = ctrl_q.reg_dst ? rd_q : rt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: a reference model predicts each EX state, the queue pairs it with the DUT.
module tb_id_ex_stage;
  typedef struct packed {
    logic [9:0]  ctrl;  // {alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [5:0]  funct;
  } id_t;

  typedef struct packed {
    id_t         f;
    logic        valid;
    logic [15:0] cnt;
  } ex_t;

  localparam logic [9:0]  C_BUBBLE = 10'b10_0000_0000;
  localparam logic [9:0]  C_ADDI   = 10'b00_0000_0110;
  localparam logic [9:0]  C_LW     = 10'b00_0011_0110;
  localparam logic [9:0]  C_RTYPE  = 10'b10_1000_0010;
  localparam logic [15:0] SAT_INIT = 16'hFFF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, flush;
  id_t  in;

  logic [1:0]  alu_op_ex;
  logic        reg_dst_ex, branch_ex, mem_read_ex, mem_2_reg_ex, mem_write_ex;
  logic        alu_src_ex, reg_write_ex, jump_ex, valid_ex, stall_req;
  logic [4:0]  rs_ex, rt_ex, rd_ex, wr_addr_ex;
  logic [31:0] data1_ex, data2_ex, imm_ex, pc_ex;
  logic [5:0]  funct_ex;
  logic [15:0] stall_cnt;

  logic [1:0]  s_alu_op_ex;
  logic        s_reg_dst_ex, s_branch_ex, s_mem_read_ex, s_mem_2_reg_ex, s_mem_write_ex;
  logic        s_alu_src_ex, s_reg_write_ex, s_jump_ex, s_valid_ex, s_stall_req;
  logic [4:0]  s_rs_ex, s_rt_ex, s_rd_ex, s_wr_addr_ex;
  logic [31:0] s_data1_ex, s_data2_ex, s_imm_ex, s_pc_ex;
  logic [5:0]  s_funct_ex;
  logic [15:0] s_stall_cnt;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .alu_op(in.ctrl[9:8]), .reg_dst(in.ctrl[7]), .branch(in.ctrl[6]), .mem_read(in.ctrl[5]),
    .mem_2_reg(in.ctrl[4]), .mem_write(in.ctrl[3]), .alu_src(in.ctrl[2]),
    .reg_write(in.ctrl[1]), .jump(in.ctrl[0]),
    .rs_id(in.rs), .rt_id(in.rt), .rd_id(in.rd),
    .data1_id(in.d1), .data2_id(in.d2), .imm_id(in.imm), .pc_id(in.pc), .funct_id(in.funct),
    .alu_op_ex(alu_op_ex), .reg_dst_ex(reg_dst_ex), .branch_ex(branch_ex),
    .mem_read_ex(mem_read_ex), .mem_2_reg_ex(mem_2_reg_ex), .mem_write_ex(mem_write_ex),
    .alu_src_ex(alu_src_ex), .reg_write_ex(reg_write_ex), .jump_ex(jump_ex),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .data1_ex(data1_ex), .data2_ex(data2_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
    .funct_ex(funct_ex), .valid_ex(valid_ex), .wr_addr_ex(wr_addr_ex),
    .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  // Second instance starts its counter near the top so saturation is reached quickly.
  id_ex_stage #(.STALL_CNT_RESET(SAT_INIT)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .alu_op(in.ctrl[9:8]), .reg_dst(in.ctrl[7]), .branch(in.ctrl[6]), .mem_read(in.ctrl[5]),
    .mem_2_reg(in.ctrl[4]), .mem_write(in.ctrl[3]), .alu_src(in.ctrl[2]),
    .reg_write(in.ctrl[1]), .jump(in.ctrl[0]),
    .rs_id(in.rs), .rt_id(in.rt), .rd_id(in.rd),
    .data1_id(in.d1), .data2_id(in.d2), .imm_id(in.imm), .pc_id(in.pc), .funct_id(in.funct),
    .alu_op_ex(s_alu_op_ex), .reg_dst_ex(s_reg_dst_ex), .branch_ex(s_branch_ex),
    .mem_read_ex(s_mem_read_ex), .mem_2_reg_ex(s_mem_2_reg_ex), .mem_write_ex(s_mem_write_ex),
    .alu_src_ex(s_alu_src_ex), .reg_write_ex(s_reg_write_ex), .jump_ex(s_jump_ex),
    .rs_ex(s_rs_ex), .rt_ex(s_rt_ex), .rd_ex(s_rd_ex),
    .data1_ex(s_data1_ex), .data2_ex(s_data2_ex), .imm_ex(s_imm_ex), .pc_ex(s_pc_ex),
    .funct_ex(s_funct_ex), .valid_ex(s_valid_ex), .wr_addr_ex(s_wr_addr_ex),
    .stall_req(s_stall_req), .stall_cnt(s_stall_cnt)
  );

  ex_t obs;
  assign obs = {alu_op_ex, reg_dst_ex, branch_ex, mem_read_ex, mem_2_reg_ex, mem_write_ex,
                alu_src_ex, reg_write_ex, jump_ex, rs_ex, rt_ex, rd_ex,
                data1_ex, data2_ex, imm_ex, pc_ex, funct_ex, valid_ex, stall_cnt};

  int unsigned errors = 0;
  int unsigned checks = 0;
  ex_t         cur;
  logic [15:0] sat_exp;
  ex_t         sb[$];

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hazard(input ex_t e, input id_t i);
    return e.valid && e.f.ctrl[5] && e.f.rt != 5'd0 && (e.f.rt == i.rs || e.f.rt == i.rt);
  endfunction

  function automatic ex_t model_next(input ex_t e, input id_t i, input logic r,
                                     input logic fl, input logic adv);
    ex_t n = e;
    if (r) begin
      n = '0;
      n.f.ctrl = C_BUBBLE;
    end else if (fl) begin
      n.f.ctrl = C_BUBBLE;
      n.valid  = 1'b0;
    end else if (adv && hazard(e, i)) begin
      n.f.ctrl = C_BUBBLE;
      n.valid  = 1'b0;
      n.cnt    = (e.cnt == 16'hFFFF) ? e.cnt : e.cnt + 16'd1;
    end else if (adv) begin
      n.f     = i;
      n.valid = 1'b1;
    end
    return n;
  endfunction

  // One clock: drive, check the combinational stall, push prediction, clock, pop and compare.
  task automatic step(input id_t i, input logic r, input logic fl, input logic adv);
    ex_t e;
    logic stall_pred;
    in = i; rst = r; flush = fl; en = adv;
    #1;
    stall_pred = hazard(cur, i);
    chk("stall_req_pre", stall_req, stall_pred);
    sb.push_back(model_next(cur, i, r, fl, adv));
    if (r) sat_exp = SAT_INIT;
    else if (!fl && adv && stall_pred && sat_exp != 16'hFFFF) sat_exp = sat_exp + 16'd1;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("ex_state", obs, e);
      chk("wr_addr", wr_addr_ex, e.f.ctrl[7] ? e.f.rd : e.f.rt);
      chk("sat_cnt", s_stall_cnt, sat_exp);
      cur = e;
    end
  endtask

  function automatic id_t mk(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
    id_t x;
    x.ctrl = c; x.rs = rs; x.rt = rt; x.rd = rd;
    x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom; x.pc = $urandom;
    x.funct = 6'($urandom);
    return x;
  endfunction

  function automatic id_t rnd_id();
    id_t x = mk(10'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom));
    return x;
  endfunction

  initial begin
    id_t  x, held;
    ex_t  snap;
    cur = '0; cur.f.ctrl = C_BUBBLE; sat_exp = SAT_INIT;
    in = rnd_id(); rst = 1'b1; en = 1'b0; flush = 1'b0;

    // Reset with random inputs for two cycles
    step(rnd_id(), 1'b1, 1'($urandom), 1'($urandom));
    step(rnd_id(), 1'b1, 1'($urandom), 1'($urandom));
    chk("rst_alu_op", alu_op_ex, 2'd2);
    chk("rst_valid", valid_ex, 1'b0);
    chk("rst_cnt", stall_cnt, 16'd0);
    chk("rst_data", {data1_ex, data2_ex, imm_ex, pc_ex}, 128'd0);

    // ADDI pass-through
    x = mk(C_ADDI, 5'd3, 5'd7, 5'd9);
    x.imm = 32'hFFFF_FFFC;
    step(x, 1'b0, 1'b0, 1'b1);
    chk("addi_valid", valid_ex, 1'b1);
    chk("addi_imm", imm_ex, 32'hFFFF_FFFC);
    chk("addi_wr_addr", wr_addr_ex, 5'd7);
    chk("addi_ctrl", {alu_op_ex, alu_src_ex, reg_write_ex, mem_read_ex}, 5'b00110);

    // Load-use: lw rt=5 in EX, consumer reads r5
    step(mk(C_LW, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0, 1'b1);
    held = mk(C_RTYPE, 5'd5, 5'd2, 5'd8);
    in = held; #1;
    chk("lu_stall", stall_req, 1'b1);
    step(held, 1'b0, 1'b0, 1'b1);
    chk("lu_bubble_valid", valid_ex, 1'b0);
    chk("lu_bubble_alu", alu_op_ex, 2'd2);
    chk("lu_cnt", stall_cnt, 16'd1);
    chk("lu_stall_drop", stall_req, 1'b0);
    step(held, 1'b0, 1'b0, 1'b1);
    chk("lu_loaded_rs", rs_ex, 5'd5);
    chk("lu_loaded_wr", wr_addr_ex, 5'd8);

    // Zero register as load destination never stalls
    step(mk(C_LW, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    step(mk(C_RTYPE, 5'd0, 5'd0, 5'd4), 1'b0, 1'b0, 1'b1);
    chk("zero_valid", valid_ex, 1'b1);
    chk("zero_cnt", stall_cnt, 16'd1);

    // Flush beats stall
    step(mk(C_LW, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0, 1'b1);
    step(mk(C_RTYPE, 5'd5, 5'd5, 5'd6), 1'b0, 1'b1, 1'b1);
    chk("flush_cnt", stall_cnt, 16'd1);
    chk("flush_valid", valid_ex, 1'b0);

    // en=0 with a hazard holds everything
    step(mk(C_LW, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0, 1'b1);
    snap = obs;
    step(mk(C_RTYPE, 5'd5, 5'd1, 5'd6), 1'b0, 1'b0, 1'b0);
    chk("hold_all", obs, snap);
    chk("hold_stall", stall_req, 1'b1);

    // Reset mid-stall, then a normal load
    step(mk(C_RTYPE, 5'd5, 5'd1, 5'd6), 1'b1, 1'b0, 1'b1);
    step(mk(C_RTYPE, 5'd5, 5'd1, 5'd6), 1'b0, 1'b0, 1'b1);
    chk("post_rst_valid", valid_ex, 1'b1);
    chk("post_rst_cnt", stall_cnt, 16'd0);

    // Randomised mix of hazards, flushes and holds
    for (int n = 0; n < 300; n++)
      step(rnd_id(), 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) != 0));

    // Saturation: back-to-back dependent loads give a bubble every other cycle
    step(mk(C_LW, 5'd5, 5'd5, 5'd0), 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 60; n++) step(mk(C_LW, 5'd5, 5'd5, 5'd0), 1'b0, 1'b0, 1'b1);
    chk("sat_top", s_stall_cnt, 16'hFFFF);
    chk("main_cnt", stall_cnt, 16'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 en  in  1  pipeline advance; 0 SHALL hold all EX-side registers.
REQ-004 flush  in  1  squash; the next EX contents SHALL be a bubble.
REQ-005 alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump  in  10 total  ID-stage control bundle from the decoder.
REQ-006 rs_id, rt_id, rd_id  in  5 each  ID register addresses.
REQ-007 data1_id, data2_id, imm_id, pc_id  in  32 each  register-file reads, sign-extended immediate, PC+4.
REQ-008 funct_id  in  6  instruction function field.
REQ-009 *_ex outputs  out  same widths as REQ-005..REQ-008  registered copies of every ID input.
REQ-010 valid_ex  out  1  EX holds a real instruction.
REQ-011 wr_addr_ex  out  5  destination register: rd_ex if reg_dst_ex, else rt_ex.
REQ-012 stall_req  out  1  load-use hazard; upstream SHALL hold PC and IF/ID while 1.
REQ-013 stall_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-014 Bubble SHALL be: every control output 0, alu_op_ex = 2'd2 (R-type), valid_ex = 0; data/address outputs SHALL keep their previous values.
REQ-015 stall_req SHALL be combinational from EX registers and ID addresses: valid_ex & mem_read_ex & (rt_ex != 0) & (rt_ex == rs_id | rt_ex == rt_id).
REQ-016 Per-edge priority: rst > flush > (en & stall_req -> bubble) > (en -> load ID inputs, valid_ex = 1) > hold.
REQ-017 Latency SHALL be exactly one cycle from ID inputs to *_ex outputs when en = 1 and no stall/flush.
REQ-018 A load-use hazard SHALL insert exactly one bubble; on the following cycle stall_req SHALL deassert (EX then holds the bubble), and the held ID instruction SHALL load.
REQ-019 en = 0 with stall_req = 1 SHALL hold (no bubble, no count increment).
REQ-020 flush and stall_req simultaneously: flush SHALL win; stall_cnt SHALL NOT increment.
REQ-021 stall_cnt SHALL increment by 1 on every hazard bubble of REQ-018 and SHALL saturate at 16'hFFFF without wrapping.
REQ-022 Register 0 as load destination SHALL never raise stall_req.
REQ-023 wr_addr_ex SHALL be combinational from registered reg_dst_ex, rd_ex, rt_ex.

Reset
REQ-024 On rst all outputs SHALL be: control = bubble per REQ-014, all data/address outputs 0, valid_ex = 0, stall_cnt = 0, hence stall_req = 0.
REQ-025 rst asserted mid-stall SHALL discard the stalled state; the first cycle after rst deasserts SHALL behave as a normal load when en = 1.

Structure
REQ-026 Package cpu_pkg SHALL hold: ALU-op encodings (ADD 2'd0, SUB 2'd1, R_TYPE 2'd2), bubble control value, register-address width 5, data width 32.
REQ-027 Sub-module hazard_detect SHALL implement REQ-015 and REQ-022 only; id_ex_stage SHALL own all registers and the counter.

Verification
REQ-028 Reset: rst = 1 for 2 cycles with random inputs -> all outputs 0 except alu_op_ex = 2, stall_req = 0, stall_cnt = 0.
REQ-029 Pass-through: en = 1, ADDI bundle (alu_src = 1, reg_write = 1, alu_op = 0), imm_id = 32'hFFFF_FFFC -> next cycle identical *_ex values, valid_ex = 1, wr_addr_ex = rt_id.
REQ-030 Load-use: EX = lw rt = 5, ID rs = 5 -> stall_req = 1, next cycle bubble, stall_cnt = 1, stall_req = 0, following cycle ID instruction in EX.
REQ-031 Zero reg: EX = lw rt = 0, ID rs = 0 -> stall_req = 0, no bubble.
REQ-032 Flush vs stall: hazard of REQ-030 with flush = 1 -> bubble, stall_cnt unchanged; en = 0 case -> all outputs held.
REQ-033 Saturation: force 65 537 hazard bubbles -> stall_cnt = 16'hFFFF and stays there.
